// File: rtl/sram_1rw1r_responder.sv
// sram_1rw1r_responder: flop-based stand-in for the 1RW+1R SRAM macro port.
//   clk, rst_n           shared clock, async active-low reset (clears memory and outputs)
//   csb0/web0/wmask0     port 0 chip select (low), write enable (low), byte write mask
//   addr0/din0/dout0     port 0 address, write data, registered read data
//   csb1/addr1/dout1     port 1 (read-only) chip select (low), address, registered read data
//   collision            registered: previous edge had a port 0 write and port 1 read of the same word
module sram_1rw1r_responder #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 16,
   parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  csb0,
   input  logic                  web0,
   input  logic [NUM_WMASKS-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic [DATA_WIDTH-1:0] dout0,
   input  logic                  csb1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic [DATA_WIDTH-1:0] dout1,
   output logic                  collision
);
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [DATA_WIDTH-1:0] dout0_q, dout0_d, dout1_q, dout1_d;
   logic                  collision_q, collision_d;
   logic                  in0, in1, wr0, rd0, rd1;
   logic [IW-1:0]         idx0, idx1;
   // Range check in 32 bits so DEPTH == 2**ADDR_WIDTH does not wrap
   assign in0  = 32'(addr0) < DEPTH;
   assign in1  = 32'(addr1) < DEPTH;
   assign idx0 = IW'(addr0);
   assign idx1 = IW'(addr1);
   assign wr0  = !csb0 && !web0;
   assign rd0  = !csb0 && web0;
   assign rd1  = !csb1;
   always_comb begin
      mem_d = mem_q;
      for (int b = 0; b < NUM_WMASKS; b++)
         if (wr0 && in0 && wmask0[b]) mem_d[idx0][8*b +: 8] = din0[8*b +: 8];
   end
   // Reads see mem_q, so a same-edge port 1 read returns the pre-write word
   assign dout0_d     = rd0 ? (in0 ? mem_q[idx0] : '0) : dout0_q;
   assign dout1_d     = rd1 ? (in1 ? mem_q[idx1] : '0) : dout1_q;
   assign collision_d = wr0 && |wmask0 && rd1 && in0 && addr1 == addr0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q       <= '{default: '0};
         dout0_q     <= '0;
         dout1_q     <= '0;
         collision_q <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         dout0_q     <= dout0_d;
         dout1_q     <= dout1_d;
         collision_q <= collision_d;
      end
   end
   assign dout0     = dout0_q;
   assign dout1     = dout1_q;
   assign collision = collision_q;
endmodule

// File: tb/tb_sram_1rw1r_responder.sv
// tb_sram_1rw1r_responder: directed checks on 8-bit, 16-bit and DEPTH=12 instances.
module tb_sram_1rw1r_responder;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   int n_chk = 0, n_fail = 0;

   logic       a_csb0 = 1, a_web0 = 1, a_wm = 0, a_csb1 = 1, a_col;
   logic [3:0] a_ad0 = 0, a_ad1 = 0;
   logic [7:0] a_din = 0, a_do0, a_do1;
   sram_1rw1r_responder u8 (.clk(clk), .rst_n(rst_n), .csb0(a_csb0), .web0(a_web0), .wmask0(a_wm),
      .addr0(a_ad0), .din0(a_din), .dout0(a_do0), .csb1(a_csb1), .addr1(a_ad1), .dout1(a_do1), .collision(a_col));

   logic        b_csb0 = 1, b_web0 = 1, b_csb1 = 1, b_col;
   logic [1:0]  b_wm = 0;
   logic [3:0]  b_ad0 = 0, b_ad1 = 0;
   logic [15:0] b_din = 0, b_do0, b_do1;
   sram_1rw1r_responder #(.DATA_WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .csb0(b_csb0), .web0(b_web0), .wmask0(b_wm),
      .addr0(b_ad0), .din0(b_din), .dout0(b_do0), .csb1(b_csb1), .addr1(b_ad1), .dout1(b_do1), .collision(b_col));

   logic       c_csb0 = 1, c_web0 = 1, c_wm = 0, c_csb1 = 1, c_col;
   logic [3:0] c_ad0 = 0, c_ad1 = 0;
   logic [7:0] c_din = 0, c_do0, c_do1;
   sram_1rw1r_responder #(.DEPTH(12)) u12 (.clk(clk), .rst_n(rst_n), .csb0(c_csb0), .web0(c_web0), .wmask0(c_wm),
      .addr0(c_ad0), .din0(c_din), .dout0(c_do0), .csb1(c_csb1), .addr1(c_ad1), .dout1(c_do1), .collision(c_col));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic p0(input logic csb, input logic web, input logic wm, input logic [3:0] ad, input logic [7:0] d);
      a_csb0 = csb; a_web0 = web; a_wm = wm; a_ad0 = ad; a_din = d;
   endtask

   task automatic p1(input logic csb, input logic [3:0] ad);
      a_csb1 = csb; a_ad1 = ad;
   endtask

   initial begin
      #12;
      chk("rst_do0", a_do0, 0); chk("rst_do1", a_do1, 0); chk("rst_col", a_col, 0);
      chk("rst16_do1", b_do1, 0); chk("rst12_do0", c_do0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         p0(0, 1, 0, 4'(i), 0); p1(0, 4'(i));
         tick();
         chk("init_do0", a_do0, 0); chk("init_do1", a_do1, 0); chk("init_col", a_col, 0);
      end
      // Write 0x3C to addr 5 and read it back so dout0 holds a nonzero value
      p0(0, 0, 1, 5, 8'h3C); p1(1, 0);
      tick();
      p0(0, 1, 0, 5, 0);
      tick();
      chk("rd5", a_do0, 8'h3C);
      p0(0, 0, 1, 3, 8'hA5);
      tick();
      chk("wr_hold", a_do0, 8'h3C);
      p0(0, 1, 0, 3, 0);
      tick();
      chk("rd3", a_do0, 8'hA5);
      // Empty mask write changes nothing
      p0(0, 0, 0, 3, 8'hFF);
      tick();
      chk("wm0_hold", a_do0, 8'hA5);
      // Deselected port ignores write controls
      p0(1, 0, 1, 3, 8'h99);
      tick();
      chk("idle_hold", a_do0, 8'hA5);
      p0(0, 1, 0, 3, 0);
      tick();
      chk("rd3_again", a_do0, 8'hA5);
      // Read-before-write collision on addr 7
      p0(0, 0, 1, 7, 8'h11);
      tick();
      p0(0, 0, 1, 7, 8'h5A); p1(0, 7);
      tick();
      chk("rbw_do1", a_do1, 8'h11); chk("rbw_col", a_col, 1);
      p0(1, 1, 0, 0, 0);
      tick();
      chk("new_do1", a_do1, 8'h5A); chk("col_clear", a_col, 0);
      p0(0, 1, 0, 7, 0);
      tick();
      chk("dual_do0", a_do0, 8'h5A); chk("dual_do1", a_do1, 8'h5A); chk("dual_col", a_col, 0);
      p0(0, 0, 0, 7, 8'h22);
      tick();
      chk("wm0_nocol", a_col, 0);
      p0(0, 0, 1, 6, 8'h22);
      tick();
      chk("diff_nocol", a_col, 0);
      chk("idle_do1", a_do1, 8'h5A);
      p1(1, 0); p0(1, 1, 0, 0, 0);
      // 16-bit byte lanes
      b_csb0 = 0; b_web0 = 0; b_wm = 2'b11; b_ad0 = 2; b_din = 16'h1234;
      tick();
      b_wm = 2'b01; b_din = 16'hFFFF;
      tick();
      b_csb0 = 1; b_csb1 = 0; b_ad1 = 2;
      tick();
      chk("lane_do1", b_do1, 16'h12FF);
      b_csb1 = 1; b_csb0 = 0; b_web0 = 0; b_wm = 2'b10; b_ad0 = 2; b_din = 16'hAB00;
      tick();
      b_web0 = 1;
      tick();
      chk("lane_hi", b_do0, 16'hABFF);
      b_csb0 = 1;
      // DEPTH=12: out-of-range write dropped, reads return 0
      c_csb0 = 0; c_web0 = 0; c_wm = 1; c_ad0 = 1; c_din = 8'h42;
      tick();
      c_ad0 = 13; c_din = 8'h77; c_csb1 = 0; c_ad1 = 13;
      tick();
      chk("oor_nocol", c_col, 0);
      c_web0 = 1;
      tick();
      chk("oor_do0", c_do0, 0); chk("oor_do1", c_do1, 0);
      c_ad0 = 1; c_ad1 = 1;
      tick();
      chk("a1_do0", c_do0, 8'h42); chk("a1_do1", c_do1, 8'h42);
      c_ad0 = 4'hF;
      tick();
      chk("oorF_do0", c_do0, 0);
      c_csb0 = 1; c_csb1 = 1;
      // Async reset during a pending write
      p0(0, 1, 0, 3, 0);
      tick();
      chk("pre_rst", a_do0, 8'hA5);
      p0(0, 0, 1, 3, 8'h66);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_do0", a_do0, 0); chk("arst_do1", a_do1, 0); chk("arst_col", a_col, 0);
      @(negedge clk);
      rst_n = 1'b1;
      p0(0, 1, 0, 3, 0); p1(0, 7);
      tick();
      chk("post_rst3", a_do0, 0); chk("post_rst7", a_do1, 0);
      b_csb1 = 0; b_ad1 = 2;
      tick();
      chk("post_rst16", b_do1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
